instruction_cache: RTL and testbench
====================================

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 The block SHALL provide port clock, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL provide port read, input, 1 bit: CPU instruction fetch request.
REQ-005 The block SHALL provide port address, input, 10 bits: CPU byte address (tag [9:7], index [6:4], word offset [3:2], byte offset [1:0]).
REQ-006 The block SHALL provide port readinst, output, 32 bits: fetched instruction word.
REQ-007 The block SHALL provide port busywait, output, 1 bit: CPU stall request.
REQ-008 The block SHALL provide port mem_read, output, 1 bit: block read request to instruction memory.
REQ-009 The block SHALL provide port mem_address, output, 6 bits: block address to instruction memory.
REQ-010 The block SHALL provide port mem_readinst, input, 128 bits: returned 16-byte block, with byte k at bits [8k+7:8k].
REQ-011 The block SHALL provide port mem_busywait, input, 1 bit: instruction memory busy indication.

Function
REQ-012 The block SHALL be a direct-mapped cache of 8 lines, each holding a 128-bit data block, a 3-bit tag and 1 valid bit.
REQ-013 The block SHALL ignore address[1:0], since instructions are word-aligned.
REQ-014 Hit SHALL be defined as read=1, valid[index]=1 and tag[index]=address[9:7], evaluated combinationally in state IDLE.
REQ-015 On a hit, readinst SHALL equal bits [32w+31:32w] of line[index], where w=address[3:2], and busywait SHALL be 0 in the same cycle (zero-cycle hit).
REQ-016 When read=0, busywait SHALL be 0, readinst SHALL hold its last value, and no state SHALL change.
REQ-017 On a miss in IDLE, busywait SHALL be 1 combinationally, and at the next rising edge the FSM SHALL move to MEM_READ and latch address[9:4] into a refill register.
REQ-018 The FSM SHALL have exactly three states: IDLE, MEM_READ and UPDATE.
REQ-019 In MEM_READ, the block SHALL drive mem_read=1, drive mem_address equal to the latched address[9:4], and hold busywait=1.
REQ-020 The FSM SHALL leave MEM_READ for UPDATE only on a rising edge where mem_busywait=0, and only after at least one full cycle in MEM_READ.
REQ-021 The FSM SHALL capture mem_readinst at the MEM_READ-to-UPDATE edge.
REQ-022 In UPDATE, the block SHALL drive mem_read=0 and busywait=1.
REQ-023 At the UPDATE exit edge, the block SHALL write the captured block, tag and valid=1 into the latched index, and the FSM SHALL return to IDLE.
REQ-024 The retried access in IDLE SHALL then hit, giving a total miss penalty of memory latency + 2 cycles.
REQ-025 In IDLE, mem_read SHALL be 0 and mem_address SHALL hold its last value.
REQ-026 A change of address during MEM_READ or UPDATE SHALL NOT alter the refill; the refill SHALL complete to the latched index and tag.
REQ-027 A conflicting tag at an index SHALL replace that line unconditionally; there is no write path and no dirty state.
REQ-028 A line fill SHALL be atomic: a partially filled line SHALL never be marked valid.

Reset
REQ-029 When reset=1 at a rising edge, all 8 valid bits SHALL clear, the FSM SHALL enter IDLE, the refill register SHALL clear, and readinst SHALL be set to 0.
REQ-030 After reset, mem_read SHALL be 0 and busywait SHALL be 0 (when read=0) from the following cycle onward.
REQ-031 Reset during MEM_READ or UPDATE SHALL abort the refill, deassert mem_read on the next cycle, and leave the target line invalid.
REQ-032 Tag and data arrays need not be cleared by reset.

Verification
REQ-033 The bench SHALL cover a cold miss: after reset, read=1, address=0x000, memory block 0 word0=0x00040019 -> busywait=1, mem_read=1, mem_address=0; after memory completes and UPDATE, readinst=0x00040019 and busywait=0.
REQ-034 The bench SHALL cover a same-block hit: following the cold miss, address=0x004 -> readinst=0x00050023 and busywait=0 in the same cycle, with mem_read remaining 0.
REQ-035 The bench SHALL cover a conflict miss: with line 0 valid at tag 0, address=0x080 (tag 1, index 0) -> miss, mem_address=0x08, and line 0 replaced; a subsequent address=0x000 misses again.
REQ-036 The bench SHALL cover reset mid-refill: reset asserted in the second cycle of MEM_READ -> mem_read=0 the next cycle, FSM in IDLE, and a re-read of the same address misses.
REQ-037 The bench SHALL cover an idle request: read=0 for 10 cycles with arbitrary address -> mem_read=0, busywait=0, and readinst unchanged.
REQ-038 The bench SHALL cover an address change during refill: address switched from 0x010 to 0x3F0 in MEM_READ -> mem_address stays 0x01 and line 1 is filled with tag 0.

Source files
------------

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache: 8 lines of 16 bytes, zero-cycle hits, and
// a single-block refill driven by a three-state FSM (IDLE/MEM_READ/UPDATE).
module instruction_cache (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  readinst,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readinst,
  input  logic         mem_busywait
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_READ = 2'd1;
  localparam logic [1:0] UPDATE   = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [7:0]   valid_q;
  logic [2:0]   tag_q  [8];
  logic [127:0] data_q [8];
  logic [5:0]   refill_q;
  logic [127:0] blk_q;
  logic [31:0]  readinst_q;

  logic [2:0]   idx, tag;
  logic [1:0]   woff;
  logic [127:0] line;
  logic [31:0]  word;
  logic         hit, miss;
  logic         unused_byte_off;

  assign idx  = address[6:4];
  assign tag  = address[9:7];
  assign woff = address[3:2];
  assign unused_byte_off = ^address[1:0];

  assign line = data_q[idx];
  assign word = line[{woff, 5'b0} +: 32];
  assign hit  = (state_q == IDLE) && read && valid_q[idx] && (tag_q[idx] == tag);
  assign miss = (state_q == IDLE) && read && !hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (miss) state_d = MEM_READ;
      MEM_READ: if (!mem_busywait) state_d = UPDATE;
      UPDATE:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign busywait    = (state_q != IDLE) || miss;
  assign readinst    = hit ? word : readinst_q;
  assign mem_read    = (state_q == MEM_READ);
  // Refill register only moves on a miss, so it also holds mem_address in IDLE.
  assign mem_address = refill_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      refill_q   <= '0;
      readinst_q <= '0;
    end else begin
      state_q <= state_d;
      if (hit)  readinst_q <= word;
      if (miss) refill_q   <= address[9:4];
      if (state_q == UPDATE) valid_q[refill_q[2:0]] <= 1'b1;
    end
  end

  // Block, tag and data are written in one edge so a line is never half-valid.
  always_ff @(posedge clock) begin
    if (state_q == MEM_READ && !mem_busywait) blk_q <= mem_readinst;
    if (!reset && state_q == UPDATE) begin
      tag_q[refill_q[2:0]]  <= refill_q[5:3];
      data_q[refill_q[2:0]] <= blk_q;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: stimulus pushes expected fetch data,
// a negedge monitor pops and compares whenever a fetch completes.
module tb_instruction_cache;

  logic         clock = 1'b0;
  logic         reset, read;
  logic [9:0]   address;
  logic [31:0]  readinst;
  logic         busywait, mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readinst;
  logic         mem_busywait;

  int checks = 0;
  int errors = 0;
  logic [31:0] expq [$];
  logic [3:0]  mcnt;

  localparam int MISS_STALLS = 6;  // 1 IDLE + 4 MEM_READ + 1 UPDATE

  instruction_cache dut (
    .clock(clock), .reset(reset), .read(read), .address(address),
    .readinst(readinst), .busywait(busywait), .mem_read(mem_read),
    .mem_address(mem_address), .mem_readinst(mem_readinst),
    .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [5:0] b, input logic [1:0] w);
    if (b == 6'd0 && w == 2'd0) return 32'h00040019;
    if (b == 6'd0 && w == 2'd1) return 32'h00050023;
    return {8'hA5, 2'b00, b, 14'h0000, w};
  endfunction

  // Memory: busy for 3 cycles of mem_read, done on the 4th.
  always @(posedge clock) mcnt <= mem_read ? mcnt + 4'd1 : 4'd0;
  assign mem_busywait = mem_read && (mcnt < 4'd3);
  always_comb begin
    mem_readinst = '0;
    for (int k = 0; k < 4; k++) mem_readinst[32*k +: 32] = mem_word(mem_address, 2'(k));
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && read && !busywait) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_fetch: got %h expected none", readinst);
      end else begin
        logic [31:0] e;
        e = expq.pop_front();
        if (readinst !== e) begin
          errors++;
          $display("FAIL fetch_data: got %h expected %h", readinst, e);
        end
      end
    end
  end

  task automatic fetch(input string name, input logic [9:0] a, input logic [31:0] exp,
                       input int exp_stalls, input logic [5:0] exp_ma);
    int stalls = 0;
    bit saw_mr = 0;
    bit done = 0;
    logic [5:0] ma = '0;
    @(posedge clock); #1;
    read = 1'b1; address = a;
    expq.push_back(exp);
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clock);
      if (mem_read) begin saw_mr = 1; ma = mem_address; end
      if (busywait) stalls++; else done = 1;
    end
    chk({name, "_timeout"}, 32'(done), 32'd1);
    chk({name, "_stalls"}, stalls, exp_stalls);
    chk({name, "_mem_read_seen"}, 32'(saw_mr), 32'(exp_stalls != 0));
    if (exp_stalls != 0) chk({name, "_mem_address"}, 32'(ma), 32'(exp_ma));
    @(posedge clock); #1;
    read = 1'b0;
  endtask

  task automatic wait_mem_read(input string name);
    bit ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clock);
      if (mem_read) ok = 1;
    end
    chk({name, "_mem_read_start"}, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [31:0] last;
    int bad;
    bit left;
    reset = 1'b1; read = 1'b0; address = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_busywait", 32'(busywait), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_readinst", readinst, 32'd0);

    fetch("cold_miss", 10'h000, 32'h00040019, MISS_STALLS, 6'h00);
    fetch("same_blk_hit", 10'h004, 32'h00050023, 0, 6'h00);
    fetch("word3_hit", 10'h00C, mem_word(6'h00, 2'd3), 0, 6'h00);
    last = mem_word(6'h00, 2'd3);

    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      address = 10'($urandom);
      @(negedge clock);
      chk("idle_mem_read", 32'(mem_read), 32'd0);
      chk("idle_busywait", 32'(busywait), 32'd0);
      chk("idle_readinst", readinst, last);
    end

    fetch("conflict_miss", 10'h080, mem_word(6'h08, 2'd0), MISS_STALLS, 6'h08);
    fetch("conflict_refetch", 10'h000, 32'h00040019, MISS_STALLS, 6'h00);

    // Reset in the second MEM_READ cycle.
    @(posedge clock); #1;
    read = 1'b1; address = 10'h020;
    wait_mem_read("rst_mid");
    @(posedge clock); #1;
    reset = 1'b1; read = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mid_busywait", 32'(busywait), 32'd0);
    chk("rst_mid_readinst", readinst, 32'd0);
    fetch("rst_mid_refetch", 10'h020, mem_word(6'h02, 2'd0), MISS_STALLS, 6'h02);

    // Address switched while the refill for 0x010 is in flight.
    @(posedge clock); #1;
    read = 1'b1; address = 10'h010;
    wait_mem_read("addr_chg");
    @(posedge clock); #1;
    address = 10'h3F0;
    bad = 0; left = 0;
    for (int c = 0; c < 20 && !left; c++) begin
      @(negedge clock);
      if (mem_read) begin if (mem_address !== 6'h01) bad++; end
      else left = 1;
    end
    chk("addr_chg_left_mem_read", 32'(left), 32'd1);
    chk("addr_chg_mem_address_bad", bad, 0);
    chk("addr_chg_update_busy", 32'(busywait), 32'd1);
    @(posedge clock); #1;
    read = 1'b0;
    fetch("addr_chg_line1_hit", 10'h010, mem_word(6'h01, 2'd0), 0, 6'h00);
    fetch("addr_chg_3f0_miss", 10'h3F0, mem_word(6'h3F, 2'd0), MISS_STALLS, 6'h3F);

    repeat (2) @(negedge clock);
    chk("scoreboard_empty", expq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
